simple_computer_sequencer: RTL and testbench
============================================

// Module: simple_computer_sequencer
// PURPOSE
//  Program sequencer for the four-op simple computer datapath (MOVI, MVD, ADD, STR).
//  - Fetches instructions from a small synchronous program ROM.
//  - Decodes the 2-bit opcode.
//  - Drives the datapath's one-hot control vector, with a ready handshake, until the program ends.
//  - Sits between the program ROM and the datapath; software-visible via start/busy/done.
// PARAMETERS
//  PC_W      4   program counter width; ROM depth = 2**PC_W
//  PROG_LEN  16  instructions executed per run, 1..2**PC_W
//  IMM_W     4   immediate field width
// PORTS
//  clk         in   1              rising-edge clock
//  reset_n     in   1              asynchronous, active-low reset
//  start       in   1              one-cycle run request; ignored while busy=1
//  instr_addr  out  PC_W           ROM address (= pc)
//  instr_data  in   4+IMM_W        ROM data, valid 1 cycle after instr_addr
//  dp_ready    in   1              datapath accepts current ctrl this cycle
//  ctrl        out  4              one-hot {MOVI,MVD,ADD,STR} = bits {3,2,1,0}; 0 when idle
//  reg_sel     out  2              register select, from IR
//  imm         out  IMM_W          immediate, from IR
//  busy        out  1              high from the cycle after start accept until done
//  done        out  1              one-cycle pulse after last instruction accepted
//  step        in   1              only with SEQ_STEP_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Instr format: [IMM_W+3:IMM_W+2] opcode (00 MOVI, 01 MVD, 10 ADD, 11 STR), [IMM_W+1:IMM_W] reg_sel, [IMM_W-1:0] imm.
//  - Reset (async, reset_n=0): state=IDLE, pc=0, IR=0; ctrl=0, reg_sel=0, imm=0, busy=0, done=0, instr_addr=0.
//  - Reset asserted mid-run aborts immediately; no partial ctrl pulse survives. Restart needs a new start.
//  - FSM (registered outputs):
//    - IDLE: start=1 -> pc=0, FETCH. start=0 -> stay.
//    - FETCH: instr_addr=pc -> DECODE.
//    - DECODE: IR<=instr_data -> EXEC.
//    - EXEC: ctrl=onehot(IR.opcode); reg_sel and imm driven from IR. Hold all three stable while dp_ready=0.
//      - dp_ready=1 with pc==PROG_LEN-1 -> DONE.
//      - dp_ready=1 otherwise -> pc<=pc+1, FETCH.
//    - DONE: ctrl=0, done=1 for exactly one cycle, busy=0 -> IDLE.
//  - Latency: 3 cycles/instruction with dp_ready tied 1; run of N instr = 3N+1 cycles from start to done.
//  - ctrl is exactly one-hot in EXEC and all-zero in every other state. Never two bits set.
//  - pc does not wrap within a run. PROG_LEN=2**PC_W ends at pc=all-ones without incrementing.
//  - start during busy or in the DONE cycle: ignored, not queued.
//  - Unknown/X opcode cannot occur (2-bit field fully decoded); default branch -> IDLE, ctrl=0.
// CONFIGURATION
//  - SEQ_STEP_EN defined:
//    - Adds input step and state PAUSE.
//    - EXEC with dp_ready=1 and not last goes to PAUSE instead of FETCH; pc is incremented on entry.
//    - PAUSE holds ctrl=0 and busy=1; step=1 -> FETCH.
//    - Last instruction still goes directly to DONE.
//  - SEQ_STEP_EN undefined: no step port, no PAUSE state; behaviour exactly as above.
// TESTING
//  1. Reset then release, PROG_LEN=4, ROM={MOVI r1 #5, MVD r2, ADD r1, STR r3}, dp_ready=1, start pulse
//     -> ctrl 1000,0100,0010,0001 on cycles 3,6,9,12 after start; imm=5 with MOVI; done at cycle 13.
//  2. Same program, dp_ready held 0 for 4 cycles during ADD
//     -> ctrl=0010 with reg_sel=01 stable for 5 cycles, then continues; done 4 cycles later than test 1.
//  3. start pulsed again at cycle 5 of a run
//     -> ignored; exactly one done pulse; pc sequence 0,1,2,3 unchanged.
//  4. reset_n=0 asynchronously mid-EXEC (ctrl=0100)
//     -> ctrl, busy, done, pc all 0 within the same cycle; stays IDLE until next start.
//  5. PROG_LEN=16, all STR
//     -> 16 ctrl=0001 pulses, instr_addr 0..15, no wrap to 0, done at cycle 49.
//  6. SEQ_STEP_EN, program of test 1
//     -> stops in PAUSE after each of first 3 instr (busy=1, ctrl=0); each step advances one instr.

Source files
------------

// File: rtl/simple_computer_sequencer.sv
// Program sequencer for the four-op simple computer: fetch, decode and execute over a synchronous ROM.
// Optional single-step mode (PAUSE state and step input) is enabled by defining SEQ_STEP_EN.
module simple_computer_sequencer #(
    parameter int PC_W     = 4,
    parameter int PROG_LEN = 16,
    parameter int IMM_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [IMM_W+3:0]   instr_data,
    input  logic               dp_ready,
    output logic [3:0]         ctrl,
    output logic [1:0]         reg_sel,
    output logic [IMM_W-1:0]   imm,
    output logic               busy,
    output logic               done
`ifdef SEQ_STEP_EN
    ,
    input  logic               step
`endif
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
`ifdef SEQ_STEP_EN
        S_PAUSE  = 3'd5,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic [IMM_W+3:0]   ir;
    logic [3:0]         ctrl_next;
    logic               busy_next;
    logic               done_next;

    // Opcode 00 (MOVI) lands on bit 3, 11 (STR) on bit 0.
    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] base;
        base = 4'b1000;
        return base >> op;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            ctrl  <= 4'b0000;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ctrl  <= ctrl_next;
            busy  <= busy_next;
            done  <= done_next;
            if (state == S_DECODE) begin
                ir <= instr_data;
            end
        end
    end

    // Outputs are computed for the next state so they register alongside it.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ctrl_next  = 4'b0000;
        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = S_EXEC;
                ctrl_next  = op_onehot(instr_data[IMM_W+3:IMM_W+2]);
            end
            S_EXEC: begin
                if (dp_ready) begin
                    if (pc == LAST_PC) begin
                        state_next = S_DONE;
                    end else begin
                        pc_next = pc + 1'b1;
`ifdef SEQ_STEP_EN
                        state_next = S_PAUSE;
`else
                        state_next = S_FETCH;
`endif
                    end
                end else begin
                    ctrl_next = op_onehot(ir[IMM_W+3:IMM_W+2]);
                end
            end
`ifdef SEQ_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_next = S_FETCH;
                end
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next == S_FETCH) || (state_next == S_DECODE) ||
`ifdef SEQ_STEP_EN
                    (state_next == S_PAUSE) ||
`endif
                    (state_next == S_EXEC);
        done_next = (state_next == S_DONE);
    end

    assign instr_addr = pc;
    assign reg_sel    = ir[IMM_W+1:IMM_W];
    assign imm        = ir[IMM_W-1:0];

endmodule

// File: tb/tb_simple_computer_sequencer.sv
// Directed self-checking bench for simple_computer_sequencer (4-instruction and 16-instruction programs).
// With SEQ_STEP_EN defined, the single-step behaviour is exercised instead of the timing tests.
module tb_simple_computer_sequencer;

    logic       clk;
    logic       reset_n;

    logic       start_a;
    logic       dp_ready_a;
    logic [3:0] addr_a;
    logic [7:0] data_a;
    logic [3:0] ctrl_a;
    logic [1:0] reg_sel_a;
    logic [3:0] imm_a;
    logic       busy_a;
    logic       done_a;

    logic       start_b;
    logic       dp_ready_b;
    logic [3:0] addr_b;
    logic [7:0] data_b;
    logic [3:0] ctrl_b;
    logic [1:0] reg_sel_b;
    logic [3:0] imm_b;
    logic       busy_b;
    logic       done_b;

`ifdef SEQ_STEP_EN
    logic       step_a;
    logic       step_b;
`endif

    logic [7:0] rom_a [16];
    logic [7:0] rom_b [16];

    int checks;
    int failures;

    logic [3:0] exp_ctrl [4];
    logic [1:0] exp_reg  [4];

    simple_computer_sequencer #(.PC_W(4), .PROG_LEN(4), .IMM_W(4)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_a),
        .instr_addr (addr_a),
        .instr_data (data_a),
        .dp_ready   (dp_ready_a),
        .ctrl       (ctrl_a),
        .reg_sel    (reg_sel_a),
        .imm        (imm_a),
        .busy       (busy_a),
        .done       (done_a)
`ifdef SEQ_STEP_EN
        ,
        .step       (step_a)
`endif
    );

    simple_computer_sequencer #(.PC_W(4), .PROG_LEN(16), .IMM_W(4)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_b),
        .instr_addr (addr_b),
        .instr_data (data_b),
        .dp_ready   (dp_ready_b),
        .ctrl       (ctrl_b),
        .reg_sel    (reg_sel_b),
        .imm        (imm_b),
        .busy       (busy_b),
        .done       (done_b)
`ifdef SEQ_STEP_EN
        ,
        .step       (step_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROMs: data follows the address by one cycle.
    always @(posedge clk) begin
        data_a <= rom_a[addr_a];
        data_b <= rom_b[addr_b];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; on return the sequencer is in cycle 1 of the run.
    task automatic applyStimulus(input bit use_b);
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        dp_ready_a = 1'b1;
        dp_ready_b = 1'b1;
`ifdef SEQ_STEP_EN
        step_a     = 1'b0;
        step_b     = 1'b0;
`endif
        // MOVI r1 #5, MVD r2, ADD r1, STR r3
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = 8'h00;
            rom_b[i] = 8'hC3;
        end
        rom_a[0] = 8'h15;
        rom_a[1] = 8'h60;
        rom_a[2] = 8'h90;
        rom_a[3] = 8'hF0;
        exp_ctrl[0] = 4'b1000; exp_reg[0] = 2'd1;
        exp_ctrl[1] = 4'b0100; exp_reg[1] = 2'd2;
        exp_ctrl[2] = 4'b0010; exp_reg[2] = 2'd1;
        exp_ctrl[3] = 4'b0001; exp_reg[3] = 2'd3;

        #1;
        checkOutput("rst_ctrl",    32'(ctrl_a),    32'h0);
        checkOutput("rst_reg_sel", 32'(reg_sel_a), 32'h0);
        checkOutput("rst_imm",     32'(imm_a),     32'h0);
        checkOutput("rst_busy",    32'(busy_a),    32'h0);
        checkOutput("rst_done",    32'(done_a),    32'h0);
        checkOutput("rst_addr",    32'(addr_a),    32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("idle_busy", 32'(busy_a), 32'h0);

`ifdef SEQ_STEP_EN
        $display("[TB] step mode run");
        applyStimulus(1'b0);
        tick();
        tick();
        checkOutput("step_exec0_ctrl", 32'(ctrl_a), 32'(exp_ctrl[0]));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("pause_busy", 32'(busy_a), 32'h1);
            checkOutput("pause_ctrl", 32'(ctrl_a), 32'h0);
            checkOutput("pause_addr", 32'(addr_a), 32'(i + 1));
            tick();
            tick();
            checkOutput("pause_hold_ctrl", 32'(ctrl_a), 32'h0);
            checkOutput("pause_hold_busy", 32'(busy_a), 32'h1);
            checkOutput("pause_hold_done", 32'(done_a), 32'h0);
            step_a = 1'b1;
            tick();
            step_a = 1'b0;
            checkOutput("step_fetch_busy", 32'(busy_a), 32'h1);
            tick();
            tick();
            checkOutput("step_exec_ctrl", 32'(ctrl_a),    32'(exp_ctrl[i + 1]));
            checkOutput("step_exec_reg",  32'(reg_sel_a), 32'(exp_reg[i + 1]));
        end
        tick();
        checkOutput("step_done",      32'(done_a), 32'h1);
        checkOutput("step_done_busy", 32'(busy_a), 32'h0);
        checkOutput("step_done_ctrl", 32'(ctrl_a), 32'h0);
`else
        $display("[TB] basic program run");
        applyStimulus(1'b0);
        for (int c = 1; c <= 14; c++) begin
            logic [3:0] ec;
            ec = ((c % 3 == 0) && (c <= 12)) ? exp_ctrl[c / 3 - 1] : 4'b0000;
            checkOutput("t1_ctrl", 32'(ctrl_a), 32'(ec));
            checkOutput("t1_busy", 32'(busy_a), 32'(c <= 12));
            checkOutput("t1_done", 32'(done_a), 32'(c == 13));
            if ((c % 3 == 0) && (c <= 12)) begin
                checkOutput("t1_reg_sel", 32'(reg_sel_a), 32'(exp_reg[c / 3 - 1]));
                checkOutput("t1_addr",    32'(addr_a),    32'(c / 3 - 1));
            end
            if (c == 3) checkOutput("t1_imm", 32'(imm_a), 32'h5);
            tick();
        end

        $display("[TB] datapath stall during ADD");
        applyStimulus(1'b0);
        for (int c = 1; c <= 18; c++) begin
            logic [3:0] ec;
            dp_ready_a = !((c >= 9) && (c <= 12));
            ec = 4'b0000;
            if (c == 3)              ec = 4'b1000;
            if (c == 6)              ec = 4'b0100;
            if (c >= 9 && c <= 13)   ec = 4'b0010;
            if (c == 16)             ec = 4'b0001;
            checkOutput("t2_ctrl", 32'(ctrl_a), 32'(ec));
            checkOutput("t2_done", 32'(done_a), 32'(c == 17));
            if (c >= 9 && c <= 13) checkOutput("t2_reg_sel", 32'(reg_sel_a), 32'h1);
            tick();
        end
        dp_ready_a = 1'b1;

        $display("[TB] start while busy");
        begin
            int done_count;
            done_count = 0;
            applyStimulus(1'b0);
            for (int c = 1; c <= 20; c++) begin
                start_a = (c == 5);
                if (done_a) done_count++;
                if ((c % 3 == 0) && (c <= 12)) checkOutput("t3_addr", 32'(addr_a), 32'(c / 3 - 1));
                checkOutput("t3_busy", 32'(busy_a), 32'(c <= 12));
                tick();
            end
            start_a = 1'b0;
            checkOutput("t3_done_count", 32'(done_count), 32'h1);
        end

        $display("[TB] async reset mid-EXEC");
        applyStimulus(1'b0);
        for (int c = 1; c < 6; c++) tick();
        checkOutput("t4_pre_ctrl", 32'(ctrl_a), 32'h4);
        reset_n = 1'b0;
        #1;
        checkOutput("t4_ctrl", 32'(ctrl_a), 32'h0);
        checkOutput("t4_busy", 32'(busy_a), 32'h0);
        checkOutput("t4_done", 32'(done_a), 32'h0);
        checkOutput("t4_addr", 32'(addr_a), 32'h0);
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("t4_idle_busy", 32'(busy_a), 32'h0);
            checkOutput("t4_idle_ctrl", 32'(ctrl_a), 32'h0);
            checkOutput("t4_idle_addr", 32'(addr_a), 32'h0);
        end

        $display("[TB] full 16-instruction program");
        begin
            int pulses;
            int dones;
            pulses = 0;
            dones  = 0;
            applyStimulus(1'b1);
            for (int c = 1; c <= 51; c++) begin
                if (ctrl_b == 4'b0001) pulses++;
                if (done_b) dones++;
                if ((c % 3 == 0) && (c <= 48)) begin
                    checkOutput("t5_ctrl", 32'(ctrl_b), 32'h1);
                    checkOutput("t5_addr", 32'(addr_b), 32'(c / 3 - 1));
                end
                if (c == 49) begin
                    checkOutput("t5_done",      32'(done_b), 32'h1);
                    checkOutput("t5_last_addr", 32'(addr_b), 32'hF);
                end
                if (c == 50) checkOutput("t5_idle_busy", 32'(busy_b), 32'h0);
                tick();
            end
            checkOutput("t5_pulses", 32'(pulses), 32'd16);
            checkOutput("t5_dones",  32'(dones),  32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
